// File: rtl/matmul_4x4_c_drain_pkg.sv
// Shared constants, FSM encoding and lane-slice helper for the 4x4 matmul C drain stage.
`ifndef MATMUL_4X4_C_DRAIN_LANE
`define MATMUL_4X4_C_DRAIN_LANE
`define LANE(v, r) v[(r)*DWIDTH +: DWIDTH]
`endif

package matmul_4x4_c_drain_pkg;

  localparam int MM_DWIDTH          = 16;
  localparam int MM_AWIDTH          = 7;
  localparam int MM_SIZE            = 4;
  localparam int MM_FIRST_COL_CYCLE = 19;
  localparam int MM_FIFO_DEPTH      = 4;
  localparam int MM_CNT_W           = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } drain_state_e;

endpackage

// File: rtl/matmul_4x4_c_drain_sync_fifo.sv
// Synchronous FIFO with synchronous clear; simultaneous push and pop keep occupancy unchanged.
module matmul_4x4_c_drain_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_din,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push, w_do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end

  // NOTE: storage is not reset; occupancy alone decides validity, so it maps to plain RAM/regs.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/matmul_4x4_c_drain.sv
// Drains the systolic tile's staggered C rows: de-skews lanes into column words,
// buffers them and writes them to C memory under a ready handshake, then flags done.
module matmul_4x4_c_drain
  import matmul_4x4_c_drain_pkg::*;
#(
  parameter int DWIDTH          = MM_DWIDTH,
  parameter int AWIDTH          = MM_AWIDTH,
  parameter int FIRST_COL_CYCLE = MM_FIRST_COL_CYCLE,
  parameter int FIFO_DEPTH      = MM_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [MM_SIZE*DWIDTH-1:0] c_data_in,
  input  logic [AWIDTH-1:0]         c_base_addr,
  input  logic                      c_ready,
  output logic                      c_we,
  output logic [AWIDTH-1:0]         c_addr,
  output logic [MM_SIZE*DWIDTH-1:0] c_data,
  output logic                      done
);

  localparam int BW = MM_SIZE * DWIDTH;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [MM_CNT_W-1:0] CNT_ARM = MM_CNT_W'(FIRST_COL_CYCLE + 2);
  localparam logic [MM_CNT_W-1:0] CNT_MAX = '1;

  drain_state_e            r_state, w_state_nxt;
  logic [MM_CNT_W-1:0]     r_cnt;
  logic                    r_start_d;
  logic                    w_start_rise, w_push, w_pop, w_clr;
  logic [2:0][DWIDTH-1:0]  r_d0;
  logic [1:0][DWIDTH-1:0]  r_d1;
  logic [DWIDTH-1:0]       r_d2;
  logic [BW-1:0]           w_col, w_fifo_dout, r_last;
  logic                    w_empty, w_full;
  logic [CW-1:0]           w_count;
  logic [1:0]              r_push_k, r_wr_k;
  logic [AWIDTH-1:0]       r_base;

  assign w_start_rise = start && !r_start_d;
  assign w_clr        = !start;
  assign w_pop        = c_we && c_ready;

  assign c_we   = (w_count != '0);
  assign c_data = w_empty ? r_last : w_fifo_dout;
  assign c_addr = r_base + AWIDTH'(r_wr_k);
  assign done   = (r_state == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_start_d <= 1'b0;
    end else begin
      r_start_d <= start;
      if (!start)                r_cnt <= '0;
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + MM_CNT_W'(1);
    end
  end

  // Lane r is delayed (3-r) cycles so all four rows of column k line up together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d0 <= '0;
      r_d1 <= '0;
      r_d2 <= '0;
    end else if (!start) begin
      r_d0 <= '0;
      r_d1 <= '0;
      r_d2 <= '0;
    end else begin
      r_d0 <= {r_d0[1:0], `LANE(c_data_in, 0)};
      r_d1 <= {r_d1[0], `LANE(c_data_in, 1)};
      r_d2 <= `LANE(c_data_in, 2);
    end
  end

  always_comb begin
    w_col = '0;
    `LANE(w_col, 0) = r_d0[2];
    `LANE(w_col, 1) = r_d1[1];
    `LANE(w_col, 2) = r_d2;
    `LANE(w_col, 3) = `LANE(c_data_in, 3);
  end

  // NOTE: defaults come first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    if (!start) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (w_start_rise) w_state_nxt = ST_WAIT;
        ST_WAIT:    if (r_cnt == CNT_ARM) w_state_nxt = ST_CAPTURE;
        ST_CAPTURE: begin
          w_push = 1'b1;
          if (r_push_k == 2'd3) w_state_nxt = ST_DRAIN;
        end
        ST_DRAIN:   if (w_pop && r_wr_k == 2'd3) w_state_nxt = ST_DONE;
        ST_DONE:    w_state_nxt = ST_DONE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_push_k <= '0;
      r_wr_k   <= '0;
      r_base   <= '0;
      r_last   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) r_last <= w_fifo_dout;
      if (!start) begin
        r_push_k <= '0;
        r_wr_k   <= '0;
      end else begin
        if (w_push) r_push_k <= r_push_k + 2'd1;
        if (w_pop)  r_wr_k   <= r_wr_k + 2'd1;
        if (r_state == ST_IDLE && w_start_rise) r_base <= c_base_addr;
      end
    end
  end

  matmul_4x4_c_drain_sync_fifo #(
    .WIDTH (BW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_col),
    .o_dout  (w_fifo_dout),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  // Exactly four pushes per tile into a buffer of at least four entries can never overflow.
  assert property (@(posedge clk) disable iff (reset) !(w_push && w_full && !w_pop));

endmodule

// File: tb/tb_matmul_4x4_c_drain.sv
// Directed bench for matmul_4x4_c_drain: drives staggered C rows and scores every write.
module tb_matmul_4x4_c_drain;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] c_data_in;
  logic [6:0]  c_base_addr;
  logic        c_ready;
  logic        c_we;
  logic [6:0]  c_addr;
  logic [63:0] c_data;
  logic        done;

  matmul_4x4_c_drain dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .c_data_in   (c_data_in),
    .c_base_addr (c_base_addr),
    .c_ready     (c_ready),
    .c_we        (c_we),
    .c_addr      (c_addr),
    .c_data      (c_data),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          tb_cnt   = 0;
  logic [15:0] seed     = 16'h0;
  logic [6:0]  base     = 7'd0;
  int          n_wr     = 0;
  int          done_cnt = -1;
  int          ready_lo_from = 99;
  int          ready_lo_to   = -1;
  int          wr_cnt_q[$];
  logic [6:0]  wr_addr_q[$];
  logic [63:0] wr_data_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cnt=%0d): got %h expected %h", tag, tb_cnt, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input int k);
    logic [63:0] w;
    w = '0;
    for (int r = 0; r < 4; r++) w[r*16 +: 16] = seed + 16'(16 * r + k);
    return w;
  endfunction

  task automatic drive_lanes();
    int k;
    for (int r = 0; r < 4; r++) begin
      k = tb_cnt - 19 - r;
      if (k >= 0 && k < 4) c_data_in[r*16 +: 16] = seed + 16'(16 * r + k);
      else                 c_data_in[r*16 +: 16] = 16'hBAD0 + 16'(r);
    end
  endtask

  // One clock cycle: advance the cnt model, drive inputs, then score outputs mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
    if (!start)          tb_cnt = 0;
    else if (tb_cnt < 63) tb_cnt++;
    drive_lanes();
    c_ready = !(tb_cnt >= ready_lo_from && tb_cnt <= ready_lo_to);
    #3;
    if (c_we) begin
      if (n_wr < 4) begin
        check("c_addr", {57'd0, c_addr}, {57'd0, 7'(base + 7'(n_wr))});
        check("c_data", c_data, exp_word(n_wr));
      end else begin
        check("extra_we", {63'd0, c_we}, 64'd0);
      end
      if (c_ready) begin
        wr_cnt_q.push_back(tb_cnt);
        wr_addr_q.push_back(c_addr);
        wr_data_q.push_back(c_data);
        n_wr++;
      end
    end
    if (done && done_cnt < 0) done_cnt = tb_cnt;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic begin_tile(input logic [15:0] s, input logic [6:0] b);
    seed        = s;
    base        = b;
    c_base_addr = b;
    n_wr        = 0;
    done_cnt    = -1;
    wr_cnt_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    start       = 1'b1;
  endtask

  task automatic end_tile();
    start = 1'b0;
    step();
    check("done_clear", {63'd0, done}, 64'd0);
    check("we_clear", {63'd0, c_we}, 64'd0);
  endtask

  task automatic check_tile(input int first_wr, input int done_at);
    check("n_writes", 64'(n_wr), 64'd4);
    for (int k = 0; k < 4; k++)
      if (k < n_wr) check("wr_cycle", 64'(wr_cnt_q[k]), 64'(first_wr + k));
    check("done_cycle", 64'(done_cnt), 64'(done_at));
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    c_ready     = 1'b1;
    c_data_in   = '0;
    c_base_addr = '0;
    #12;
    check("rst_we",   {63'd0, c_we}, 64'd0);
    check("rst_addr", {57'd0, c_addr}, 64'd0);
    check("rst_data", c_data, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    reset = 1'b0;
    step();

    // Basic tile, ready held high.
    begin_tile(16'h3C00, 7'd10);
    run(30);
    check_tile(23, 27);
    check("t1_word0", wr_data_q.size() > 0 ? wr_data_q[0] : 64'd0, 64'h3C30_3C20_3C10_3C00);
    check("t1_word3", wr_data_q.size() > 3 ? wr_data_q[3] : 64'd0, 64'h3C33_3C23_3C13_3C03);
    check("t1_addr3", {57'd0, wr_addr_q.size() > 3 ? wr_addr_q[3] : 7'd0}, 64'd13);
    end_tile();

    // Backpressure: ready low for cnt 23..30.
    ready_lo_from = 23;
    ready_lo_to   = 30;
    begin_tile(16'h4000, 7'd30);
    run(38);
    check_tile(31, 35);
    ready_lo_from = 99;
    ready_lo_to   = -1;
    end_tile();

    // Address wrap from base 126.
    begin_tile(16'h3800, 7'd126);
    run(30);
    check_tile(23, 27);
    check("wrap_a0", {57'd0, wr_addr_q.size() > 0 ? wr_addr_q[0] : 7'd5}, 64'd126);
    check("wrap_a1", {57'd0, wr_addr_q.size() > 1 ? wr_addr_q[1] : 7'd5}, 64'd127);
    check("wrap_a2", {57'd0, wr_addr_q.size() > 2 ? wr_addr_q[2] : 7'd5}, 64'd0);
    check("wrap_a3", {57'd0, wr_addr_q.size() > 3 ? wr_addr_q[3] : 7'd5}, 64'd1);
    end_tile();

    // Abort mid-CAPTURE, then a clean restart.
    begin_tile(16'h4800, 7'd50);
    run(24);
    start = 1'b0;
    step();
    check("abort_we",   {63'd0, c_we}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    step();
    check("abort_empty", {63'd0, c_we}, 64'd0);
    begin_tile(16'h5000, 7'd60);
    run(30);
    check_tile(23, 27);
    end_tile();

    // Async reset between clock edges while draining a stalled FIFO.
    ready_lo_from = 23;
    ready_lo_to   = 63;
    begin_tile(16'h5400, 7'd5);
    run(28);
    check("pre_rst_we",   {63'd0, c_we}, 64'd1);
    check("pre_rst_addr", {57'd0, c_addr}, 64'd5);
    #2;
    reset = 1'b1;
    #1;
    check("async_we",   {63'd0, c_we}, 64'd0);
    check("async_addr", {57'd0, c_addr}, 64'd0);
    check("async_data", c_data, 64'd0);
    check("async_done", {63'd0, done}, 64'd0);
    start         = 1'b0;
    ready_lo_from = 99;
    ready_lo_to   = -1;
    step();
    reset = 1'b0;
    step();

    // Back-to-back tiles with a single idle cycle between them.
    begin_tile(16'h5800, 7'd40);
    run(30);
    check_tile(23, 27);
    check("done_hold", {63'd0, done}, 64'd1);
    start = 1'b0;
    step();
    check("b2b_done_low", {63'd0, done}, 64'd0);
    begin_tile(16'h6000, 7'd64);
    run(30);
    check_tile(23, 27);
    check("b2b_a0", {57'd0, wr_addr_q.size() > 0 ? wr_addr_q[0] : 7'd0}, 64'd64);
    check("b2b_a3", {57'd0, wr_addr_q.size() > 3 ? wr_addr_q[3] : 7'd0}, 64'd67);
    check("b2b_w0", wr_data_q.size() > 0 ? wr_data_q[0] : 64'd0, 64'h6030_6020_6010_6000);
    end_tile();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
